// File: rtl/minimicro_pkg.sv
`default_nettype none
// ============================================================================
// Module   : minimicro_pkg
// Purpose  : Shared types and constants for the load/store-multiple sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package minimicro_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    RDREG = 3'd2,
    MEM   = 3'd3,
    WBREG = 3'd4,
    DONE  = 3'd5
  } seq_state_t;

  localparam int         WORD_BYTES = 4;
  localparam logic [3:0] PC_REG_IDX = 4'd15;

endpackage
`default_nettype wire

// File: rtl/reg_list_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_list_sequencer_if
// Purpose  : Command, data-memory and register-file signals of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface reg_list_sequencer_if #(
  parameter int DATA_W     = 32,
  parameter int RF_ADDR_W  = 4,
  parameter int MEM_ADDR_W = 32
) ();

  logic                  start;
  logic                  is_load;
  logic [15:0]           reg_list;
  logic [MEM_ADDR_W-1:0] base_addr;
  logic                  busy;
  logic                  done;
  logic [MEM_ADDR_W-1:0] end_addr;

  logic                  mem_req;
  logic                  mem_we;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_ack;
  logic [DATA_W-1:0]     mem_rdata;

  logic [RF_ADDR_W-1:0]  rf_ra;
  logic [DATA_W-1:0]     rf_rd;
  logic [RF_ADDR_W-1:0]  rf_wa;
  logic [DATA_W-1:0]     rf_wd;
  logic                  rf_we;
  logic                  pc_we;
  logic [DATA_W-1:0]     pc_wd;

  modport master (
    input  start, is_load, reg_list, base_addr, mem_ack, mem_rdata, rf_rd,
    output busy, done, end_addr, mem_req, mem_we, mem_addr, mem_wdata,
           rf_ra, rf_wa, rf_wd, rf_we, pc_we, pc_wd
  );

  modport slave (
    output start, is_load, reg_list, base_addr, mem_ack, mem_rdata, rf_rd,
    input  busy, done, end_addr, mem_req, mem_we, mem_addr, mem_wdata,
           rf_ra, rf_wa, rf_wd, rf_we, pc_we, pc_wd
  );

endinterface
`default_nettype wire

// File: rtl/reg_list_sequencer_lowest_set_bit.sv
`default_nettype none
// ============================================================================
// Module   : lowest_set_bit
// Purpose  : 16-bit priority encoder returning the index of the lowest set bit.
// Revision : 1.0 - initial release
// ============================================================================
module lowest_set_bit (
  input  wire  [15:0] vec,
  output logic [3:0]  idx,
  output logic        any_set
);

  // Descending scan so the lowest set bit is the last assignment to land.
  always_comb begin
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (vec[i]) idx = 4'(i);
    end
  end

  assign any_set = |vec;

endmodule
`default_nettype wire

// File: rtl/reg_list_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reg_list_sequencer
// Purpose  : LDM/STM (increment-after) engine walking a register list lowest-first.
// Revision : 1.0 - initial release
// ============================================================================
module reg_list_sequencer
  import minimicro_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int RF_ADDR_W  = 4,
  parameter int MEM_ADDR_W = 32
) (
  input wire                   clk,
  input wire                   rst,
  reg_list_sequencer_if.master bus
);

  seq_state_t            r_state;
  seq_state_t            w_next;
  logic                  r_is_load;
  logic [15:0]           r_list;
  logic [MEM_ADDR_W-1:0] r_addr;
  logic [MEM_ADDR_W-1:0] r_end_addr;
  logic [3:0]            r_idx;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W-1:0]     r_rdata;
  logic [3:0]            w_idx;
  logic                  w_any;

  lowest_set_bit u_lsb (
    .vec     (r_list),
    .idx     (w_idx),
    .any_set (w_any)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = SCAN;
      SCAN:    if (!w_any)         w_next = DONE;
               else if (r_is_load) w_next = MEM;
               else                w_next = RDREG;
      RDREG:   w_next = MEM;
      MEM:     if (bus.mem_ack) w_next = r_is_load ? WBREG : SCAN;
      WBREG:   w_next = SCAN;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The address only moves on an accepted ack, which keeps mem_addr stable across wait states.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_load  <= 1'b0;
      r_list     <= '0;
      r_addr     <= '0;
      r_end_addr <= '0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
          r_is_load <= bus.is_load;
          r_list    <= bus.reg_list;
          r_addr    <= bus.base_addr;
        end
        SCAN: if (w_any) r_idx      <= w_idx;
              else       r_end_addr <= r_addr;
        RDREG: r_wdata <= bus.rf_rd;
        MEM: if (bus.mem_ack) begin
          r_list <= r_list & ~(16'd1 << r_idx);
          r_addr <= r_addr + MEM_ADDR_W'(WORD_BYTES);
          if (r_is_load) r_rdata <= bus.mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // Strobes are gated by rst so an abort takes effect in the cycle it is raised.
  always_comb begin
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.rf_we     = 1'b0;
    bus.pc_we     = 1'b0;
    bus.end_addr  = r_end_addr;
    bus.mem_addr  = r_addr;
    bus.mem_wdata = r_wdata;
    bus.rf_ra     = RF_ADDR_W'(r_idx);
    bus.rf_wa     = RF_ADDR_W'(r_idx);
    bus.rf_wd     = r_rdata;
    bus.pc_wd     = r_rdata;
    case (r_state)
      SCAN, RDREG, WBREG: bus.busy = 1'b1;
      MEM: begin
        bus.busy    = 1'b1;
        bus.mem_req = ~rst;
        bus.mem_we  = ~rst & ~r_is_load;
      end
      DONE: bus.done = 1'b1;
      default: ;
    endcase
    if ((r_state == WBREG) && !rst) begin
      if (r_idx == PC_REG_IDX) bus.pc_we = 1'b1;
      else                     bus.rf_we = 1'b1;
    end
  end

endmodule
`default_nettype wire
